// File: rtl/div36x18_seq.sv
// Sequential restoring divider: NW-bit dividend by DW-bit divisor, one quotient
// bit per clock, valid/ready on both sides, one operation in flight.
module div36x18_seq #(
  parameter int NW = 36,
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(NW + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [NW-1:0] q_r;
  logic [DW:0]   r_r;
  logic [DW-1:0] d_r;
  logic [CW-1:0] cnt;

  logic [DW:0]   t;
  logic          ge;
  logic [DW:0]   r_nxt;
  logic [NW-1:0] q_nxt;

  // One restoring step: the dividend bit shifted out of Q enters the partial
  // remainder, and the trial subtraction decides the next quotient bit.
  always_comb begin
    t     = {r_r[DW-1:0], q_r[NW-1]};
    ge    = (t >= {1'b0, d_r});
    r_nxt = ge ? (t - {1'b0, d_r}) : t;
    q_nxt = {q_r[NW-2:0], ge};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      q_r         <= '0;
      r_r         <= '0;
      d_r         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              // Zero divisor skips the iterations and reports a saturated quotient.
              quotient    <= '1;
              remainder   <= dividend[DW-1:0];
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              q_r   <= dividend;
              d_r   <= divisor;
              r_r   <= '0;
              cnt   <= CW'(NW);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          q_r <= q_nxt;
          r_r <= r_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt[DW-1:0];
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
